// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
//
// Purpose:
//   WIDTH-bit storage/shift primitive with true and complement outputs.
//   Each enabled clock edge applies one operation selected by MODE: hold,
//   shift right/left with serial input, parallel load, rotate right/left,
//   clear to RESET_VALUE, or bitwise invert. A saturating counter tracks
//   the number of shift/rotate operations since the last load, clear or
//   reset.
//
// Ports:
//   CLK      in   1      clock, all state changes on the rising edge
//   RST_n    in   1      synchronous active-low reset (priority over EN/MODE)
//   EN       in   1      clock enable, 0 holds Q, Qn and CNT
//   MODE     in   3      operation select
//   D        in   WIDTH  parallel load data
//   SIR      in   1      serial input for shift-right (enters at MSB)
//   SIL      in   1      serial input for shift-left (enters at LSB)
//   Q        out  WIDTH  register contents
//   Qn       out  WIDTH  registered complement of Q
//   CNT      out  CNT_W  saturating shift/rotate count
//   CNT_SAT  out  1      high when CNT is at its maximum value
// -----------------------------------------------------------------------------
module universal_shift_reg #(
    parameter int                 WIDTH       = 4,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}},
    parameter int                 CNT_W       = 4
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIR,
    input  logic             SIL,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic [CNT_W-1:0] CNT,
    output logic             CNT_SAT
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHR   = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_LOAD  = 3'b011,
        MODE_ROR   = 3'b100,
        MODE_ROL   = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_INV   = 3'b111
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qn;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_q_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;

    // Saturating increment used by every shift/rotate mode.
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);

    // Next-state selection for Q and CNT from EN and MODE.
    always_comb begin
        w_q_next   = r_q;
        w_cnt_next = r_cnt;
        if (EN) begin
            case (mode_e'(MODE))
                MODE_HOLD: begin
                    w_q_next   = r_q;
                    w_cnt_next = r_cnt;
                end
                MODE_SHR: begin
                    w_q_next   = {SIR, r_q[WIDTH-1:1]};
                    w_cnt_next = w_cnt_inc;
                end
                MODE_SHL: begin
                    w_q_next   = {r_q[WIDTH-2:0], SIL};
                    w_cnt_next = w_cnt_inc;
                end
                MODE_LOAD: begin
                    w_q_next   = D;
                    w_cnt_next = CNT_ZERO;
                end
                MODE_ROR: begin
                    w_q_next   = {r_q[0], r_q[WIDTH-1:1]};
                    w_cnt_next = w_cnt_inc;
                end
                MODE_ROL: begin
                    w_q_next   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                    w_cnt_next = w_cnt_inc;
                end
                MODE_CLEAR: begin
                    w_q_next   = RESET_VALUE;
                    w_cnt_next = CNT_ZERO;
                end
                MODE_INV: begin
                    w_q_next   = ~r_q;
                    w_cnt_next = r_cnt;
                end
                default: begin
                    w_q_next   = r_q;
                    w_cnt_next = r_cnt;
                end
            endcase
        end else begin
            w_q_next   = r_q;
            w_cnt_next = r_cnt;
        end
    end

    // State registers; Qn is loaded from the same next value as Q so the
    // pair can never disagree after the first edge.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_q   <= RESET_VALUE;
            r_qn  <= ~RESET_VALUE;
            r_cnt <= CNT_ZERO;
        end else begin
            r_q   <= w_q_next;
            r_qn  <= ~w_q_next;
            r_cnt <= w_cnt_next;
        end
    end

    assign Q       = r_q;
    assign Qn      = r_qn;
    assign CNT     = r_cnt;
    assign CNT_SAT = (r_cnt == CNT_MAX);

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SHR   = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_LOAD  = 3'b011;
    localparam logic [2:0] M_ROR   = 3'b100;
    localparam logic [2:0] M_ROL   = 3'b101;
    localparam logic [2:0] M_CLEAR = 3'b110;
    localparam logic [2:0] M_INV   = 3'b111;

    logic       CLK;
    logic       RST_n;
    logic       EN;
    logic [2:0] MODE;
    logic [3:0] D;
    logic       SIR;
    logic       SIL;

    logic [3:0] q0, qn0, cnt0, q1, qn1, cnt1;
    logic       sat0, sat1;
    logic [12:0] obs0, obs1;

    int total = 0;
    int bad   = 0;

    // Reference model state: plain integers, one entry per instance.
    int mq[2];
    int mcnt[2];
    int rv[2] = '{0, 10};

    universal_shift_reg #(.WIDTH(4), .RESET_VALUE(4'b0000), .CNT_W(4)) dut0 (
        .CLK(CLK), .RST_n(RST_n), .EN(EN), .MODE(MODE), .D(D), .SIR(SIR), .SIL(SIL),
        .Q(q0), .Qn(qn0), .CNT(cnt0), .CNT_SAT(sat0)
    );

    universal_shift_reg #(.WIDTH(4), .RESET_VALUE(4'b1010), .CNT_W(4)) dut1 (
        .CLK(CLK), .RST_n(RST_n), .EN(EN), .MODE(MODE), .D(D), .SIR(SIR), .SIL(SIL),
        .Q(q1), .Qn(qn1), .CNT(cnt1), .CNT_SAT(sat1)
    );

    assign obs0 = {q0, qn0, cnt0, sat0};
    assign obs1 = {q1, qn1, cnt1, sat1};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected {Q, Qn, CNT, CNT_SAT} from the model.
    function automatic logic [12:0] expv(input int k);
        logic [3:0] tq;
        logic [3:0] tc;
        tq = mq[k][3:0];
        tc = mcnt[k][3:0];
        return {tq, ~tq, tc, (mcnt[k] == 15)};
    endfunction

    // Drive one cycle of stimulus and advance the model on the same edge.
    task automatic do_op(input logic rst, input logic en, input logic [2:0] mode,
                         input logic [3:0] d, input logic sir, input logic sil);
        @(negedge CLK);
        RST_n = rst; EN = en; MODE = mode; D = d; SIR = sir; SIL = sil;
        @(posedge CLK);
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                mq[k] = rv[k];
                mcnt[k] = 0;
            end else if (en) begin
                case (mode)
                    M_SHR:   begin mq[k] = mq[k] / 2 + int'(sir) * 8;        mcnt[k] = (mcnt[k] < 15) ? mcnt[k] + 1 : 15; end
                    M_SHL:   begin mq[k] = (mq[k] * 2) % 16 + int'(sil);     mcnt[k] = (mcnt[k] < 15) ? mcnt[k] + 1 : 15; end
                    M_LOAD:  begin mq[k] = int'(d);                          mcnt[k] = 0; end
                    M_ROR:   begin mq[k] = mq[k] / 2 + (mq[k] % 2) * 8;      mcnt[k] = (mcnt[k] < 15) ? mcnt[k] + 1 : 15; end
                    M_ROL:   begin mq[k] = (mq[k] * 2) % 16 + mq[k] / 8;     mcnt[k] = (mcnt[k] < 15) ? mcnt[k] + 1 : 15; end
                    M_CLEAR: begin mq[k] = rv[k];                            mcnt[k] = 0; end
                    M_INV:   begin mq[k] = 15 - mq[k]; end
                    default: begin end
                endcase
            end
        end
        #1;
    endtask

    task automatic test_reset();
        do_op(1'b0, 1'b1, M_LOAD, 4'hF, 1'b0, 1'b0);
        total++;
        if (obs0 !== 13'b0000_1111_0000_0) begin
            bad++; $display("FAIL reset_dut0 got=%b exp=%b", obs0, 13'b0000_1111_0000_0);
        end
        total++;
        if (obs1 !== 13'b1010_0101_0000_0) begin
            bad++; $display("FAIL reset_dut1 got=%b exp=%b", obs1, 13'b1010_0101_0000_0);
        end
        // RST_n low between edges must not disturb the register.
        do_op(1'b1, 1'b1, M_LOAD, 4'b0101, 1'b0, 1'b0);
        @(negedge CLK);
        RST_n = 1'b0; EN = 1'b0;
        #2;
        total++;
        if (obs0 !== expv(0) || q0 !== 4'b0101) begin
            bad++; $display("FAIL reset_no_edge got=%b exp=%b", obs0, expv(0));
        end
        RST_n = 1'b1;
    endtask

    task automatic test_load_shift();
        do_op(1'b1, 1'b1, M_LOAD, 4'b1011, 1'b0, 1'b0);
        do_op(1'b1, 1'b1, M_SHR, 4'b0000, 1'b1, 1'b0);
        total++;
        if (q0 !== 4'b1101 || obs0 !== expv(0)) begin
            bad++; $display("FAIL shr got=%b exp=%b", obs0, expv(0));
        end
        do_op(1'b1, 1'b1, M_SHL, 4'b0000, 1'b1, 1'b0);
        total++;
        if (q0 !== 4'b1010 || qn0 !== 4'b0101 || cnt0 !== 4'd2 || obs0 !== expv(0)) begin
            bad++; $display("FAIL shl got=%b exp=%b", obs0, expv(0));
        end
    endtask

    task automatic test_rotate();
        logic [3:0] seq [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};
        do_op(1'b1, 1'b1, M_LOAD, 4'b1000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            do_op(1'b1, 1'b1, (i < 4) ? M_ROL : M_ROR, 4'b0000, 1'b1, 1'b1);
            total++;
            if (q0 !== seq[i] || cnt0 !== 4'(i + 1) || obs0 !== expv(0)) begin
                bad++; $display("FAIL rotate_%0d got=%b exp=%b q_exp=%b", i, obs0, expv(0), seq[i]);
            end
        end
    endtask

    task automatic test_saturation();
        do_op(1'b1, 1'b1, M_LOAD, 4'b0001, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            do_op(1'b1, 1'b1, M_ROR, 4'b0000, 1'b0, 1'b0);
            total++;
            if (cnt0 !== 4'((i < 15) ? i : 15) || sat0 !== (i >= 15) || obs0 !== expv(0)) begin
                bad++; $display("FAIL sat_%0d got=%b exp=%b", i, obs0, expv(0));
            end
        end
        do_op(1'b1, 1'b1, M_LOAD, 4'b0011, 1'b0, 1'b0);
        total++;
        if (cnt0 !== 4'd0 || sat0 !== 1'b0 || obs0 !== expv(0)) begin
            bad++; $display("FAIL sat_clear_by_load got=%b exp=%b", obs0, expv(0));
        end
    endtask

    task automatic test_enable_inv();
        do_op(1'b1, 1'b1, M_LOAD, 4'b0110, 1'b0, 1'b0);
        do_op(1'b1, 1'b1, M_ROL, 4'b0000, 1'b0, 1'b0);
        do_op(1'b1, 1'b1, M_LOAD, 4'b0110, 1'b0, 1'b0);
        do_op(1'b1, 1'b0, M_SHL, 4'b1111, 1'b1, 1'b1);
        total++;
        if (q0 !== 4'b0110 || cnt0 !== 4'd0 || obs0 !== expv(0)) begin
            bad++; $display("FAIL en_low got=%b exp=%b", obs0, expv(0));
        end
        do_op(1'b1, 1'b1, M_INV, 4'b0000, 1'b1, 1'b1);
        total++;
        if (q0 !== 4'b1001 || qn0 !== 4'b0110 || obs0 !== expv(0)) begin
            bad++; $display("FAIL inv got=%b exp=%b", obs0, expv(0));
        end
        do_op(1'b1, 1'b1, M_HOLD, 4'b1111, 1'b1, 1'b1);
        total++;
        if (q0 !== 4'b1001 || obs0 !== expv(0)) begin
            bad++; $display("FAIL hold got=%b exp=%b", obs0, expv(0));
        end
    endtask

    task automatic test_mid_reset_clear();
        do_op(1'b1, 1'b1, M_LOAD, 4'b0011, 1'b0, 1'b0);
        do_op(1'b1, 1'b1, M_ROL, 4'b0000, 1'b0, 1'b0);
        do_op(1'b1, 1'b1, M_ROL, 4'b0000, 1'b0, 1'b0);
        do_op(1'b0, 1'b1, M_ROL, 4'b0000, 1'b0, 1'b0);
        total++;
        if (q1 !== 4'b1010 || qn1 !== 4'b0101 || cnt1 !== 4'd0 || obs1 !== expv(1)) begin
            bad++; $display("FAIL mid_reset got=%b exp=%b", obs1, expv(1));
        end
        do_op(1'b1, 1'b1, M_SHR, 4'b0000, 1'b0, 1'b1);
        total++;
        if (q1 !== 4'b0101 || obs1 !== expv(1)) begin
            bad++; $display("FAIL shr_after_reset got=%b exp=%b", obs1, expv(1));
        end
        do_op(1'b1, 1'b1, M_CLEAR, 4'b1111, 1'b1, 1'b1);
        total++;
        if (q1 !== 4'b1010 || cnt1 !== 4'd0 || obs1 !== expv(1) || obs0 !== expv(0)) begin
            bad++; $display("FAIL clear got1=%b exp1=%b got0=%b exp0=%b", obs1, expv(1), obs0, expv(0));
        end
    endtask

    task automatic test_random();
        logic       rst, en, sir, sil;
        logic [2:0] mode;
        logic [3:0] d;
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 24) != 0);
            en   = ($urandom_range(0, 4) != 0);
            mode = 3'($urandom_range(0, 7));
            d    = 4'($urandom_range(0, 15));
            sir  = 1'($urandom_range(0, 1));
            sil  = 1'($urandom_range(0, 1));
            do_op(rst, en, mode, d, sir, sil);
            total++;
            if (obs0 !== expv(0) || obs1 !== expv(1)) begin
                bad++; $display("FAIL random_%0d mode=%b en=%b rst=%b got0=%b exp0=%b got1=%b exp1=%b",
                                i, mode, en, rst, obs0, expv(0), obs1, expv(1));
            end
        end
    endtask

    initial begin
        RST_n = 1'b1; EN = 1'b0; MODE = 3'b000; D = 4'h0; SIR = 1'b0; SIL = 1'b0;
        mq[0] = 0; mq[1] = 0; mcnt[0] = 0; mcnt[1] = 0;
        test_reset();
        test_load_shift();
        test_rotate();
        test_saturation();
        test_enable_inv();
        test_mid_reset_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
